// File: rtl/ternary_mvm_engine.sv
// rtl/ternary_mvm_engine.sv - ternary-weight matrix-vector multiply engine with streamed load/vector/result ports
// Optional build macro TERNARY_MVM_SAT_EN clamps each result to the signed IN_W range.
module ternary_mvm_engine #(
    parameter int IN_LEN  = 16,
    parameter int OUT_LEN = 8,
    parameter int IN_W    = 8,
    parameter int OUT_W   = IN_W + $clog2(IN_LEN) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy
);

    localparam int NW         = IN_LEN * OUT_LEN;
    localparam int LOAD_WORDS = NW / 8;
    localparam int MULT_WORDS = IN_LEN / 2;
    localparam int LC_W       = (LOAD_WORDS > 1) ? $clog2(LOAD_WORDS) : 1;
    localparam int MC_W       = (MULT_WORDS > 1) ? $clog2(MULT_WORDS) : 1;
    localparam int OI_W       = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, MULT, OUT} state_t;

    state_t                  state_q;
    logic [2*NW-1:0]         w_q;
    logic signed [OUT_W-1:0] acc_q [OUT_LEN];
    logic signed [OUT_W-1:0] acc_d [OUT_LEN];
    logic [1:0]              code_hi [OUT_LEN];
    logic [1:0]              code_lo [OUT_LEN];
    logic [LC_W-1:0]         load_cnt_q;
    logic [MC_W-1:0]         mult_cnt_q;
    logic [OI_W-1:0]         out_idx_q;
    logic                    out_valid_q;
    logic                    in_fire;
    logic                    out_fire;
    logic signed [IN_W-1:0]  x_hi;
    logic signed [IN_W-1:0]  x_lo;
    logic signed [OUT_W-1:0] acc_sel;

    assign in_ready  = (state_q != OUT);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign x_hi      = in_data[8 +: IN_W];
    assign x_lo      = in_data[0 +: IN_W];
    assign acc_sel   = acc_q[out_idx_q];

    // Ternary product as add/subtract/skip: 01 -> +x, 11 -> -x, else 0.
    function automatic logic signed [OUT_W-1:0] term(input logic [1:0] code,
                                                     input logic signed [IN_W-1:0] x);
        logic signed [OUT_W-1:0] xe;
        xe = {{(OUT_W-IN_W){x[IN_W-1]}}, x};
        case (code)
            2'b01:   return xe;
            2'b11:   return -xe;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        for (int o = 0; o < OUT_LEN; o++) begin
            code_hi[o] = '0;
            code_lo[o] = '0;
            for (int m = 0; m < MULT_WORDS; m++) begin
                if (mult_cnt_q == MC_W'(m)) begin
                    code_hi[o] = w_q[2*(o*IN_LEN + 2*m) +: 2];
                    code_lo[o] = w_q[2*(o*IN_LEN + 2*m + 1) +: 2];
                end
            end
            acc_d[o] = acc_q[o] + term(code_hi[o], x_hi) + term(code_lo[o], x_lo);
        end
    end

`ifdef TERNARY_MVM_SAT_EN
    localparam logic signed [OUT_W-1:0] SAT_MAX = OUT_W'(2**(IN_W-1) - 1);
    localparam logic signed [OUT_W-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        if (acc_sel > SAT_MAX)
            out_data = SAT_MAX;
        else if (acc_sel < SAT_MIN)
            out_data = SAT_MIN;
        else
            out_data = acc_sel;
    end
`else
    assign out_data = acc_sel;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            w_q         <= '0;
            load_cnt_q  <= '0;
            mult_cnt_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            for (int o = 0; o < OUT_LEN; o++) acc_q[o] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_fire) begin
                        case (in_data[15:12])
                            4'hA: state_q <= LOAD;
                            4'hF: begin
                                state_q <= MULT;
                                for (int o = 0; o < OUT_LEN; o++) acc_q[o] <= '0;
                            end
                            4'hC:    w_q <= '0;
                            default: ;
                        endcase
                    end
                end
                LOAD: begin
                    if (in_fire) begin
                        // Word k carries flat weights 8k..8k+7, i.e. bits [16k+15:16k].
                        for (int k = 0; k < LOAD_WORDS; k++) begin
                            if (load_cnt_q == LC_W'(k)) w_q[16*k +: 16] <= in_data;
                        end
                        if (load_cnt_q == LC_W'(LOAD_WORDS - 1)) begin
                            load_cnt_q <= '0;
                            state_q    <= IDLE;
                        end else begin
                            load_cnt_q <= load_cnt_q + LC_W'(1);
                        end
                    end
                end
                MULT: begin
                    if (in_fire) begin
                        for (int o = 0; o < OUT_LEN; o++) acc_q[o] <= acc_d[o];
                        if (mult_cnt_q == MC_W'(MULT_WORDS - 1)) begin
                            mult_cnt_q  <= '0;
                            out_idx_q   <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= OUT;
                        end else begin
                            mult_cnt_q <= mult_cnt_q + MC_W'(1);
                        end
                    end
                end
                OUT: begin
                    if (out_fire) begin
                        if (out_idx_q == OI_W'(OUT_LEN - 1)) begin
                            out_idx_q   <= '0;
                            out_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            out_idx_q <= out_idx_q + OI_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_mvm_engine.sv
// tb/tb_ternary_mvm_engine.sv - directed and randomized self-checking bench for ternary_mvm_engine
module tb_ternary_mvm_engine;

    localparam int IN_LEN  = 16;
    localparam int OUT_LEN = 8;
    localparam int IN_W    = 8;
    localparam int OUT_W   = 13;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] wl [16];
    logic [15:0] xv [8];
    int          expv [OUT_LEN];

    ternary_mvm_engine #(
        .IN_LEN (IN_LEN),
        .OUT_LEN(OUT_LEN),
        .IN_W   (IN_W),
        .OUT_W  (OUT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [15:0] w, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: in_ready=%0b required 1 for word %h", in_ready, w);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    function automatic int model(input int o);
        int s;
        int f;
        logic [15:0] wd;
        logic [1:0] code;
        logic signed [7:0] xb;
        s = 0;
        for (int i = 0; i < IN_LEN; i++) begin
            f    = o * IN_LEN + i;
            wd   = wl[f / 8];
            code = wd[2*(f % 8) +: 2];
            wd   = xv[i / 2];
            xb   = (i % 2 == 0) ? wd[15:8] : wd[7:0];
            if (code == 2'b01) s = s + int'(xb);
            if (code == 2'b11) s = s - int'(xb);
        end
`ifdef TERNARY_MVM_SAT_EN
        if (s > 127) s = 127;
        if (s < -128) s = -128;
`endif
        return s;
    endfunction

    task automatic load_weights(input int max_gap);
        send(16'hA000, 0);
        for (int k = 0; k < 16; k++) send(wl[k], $urandom_range(0, max_gap));
    endtask

    task automatic do_mult(input int max_gap);
        send(16'hF000, 0);
        for (int m = 0; m < 8; m++) send(xv[m], $urandom_range(0, max_gap));
    endtask

    task automatic drain(input string tag, input bit rand_stall);
        int n;
        for (int o = 0; o < OUT_LEN; o++) begin
            @(negedge clk);
            out_ready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            n = 0;
            while (!(out_valid && out_ready) && n < 200) begin
                @(negedge clk);
                out_ready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
                n++;
            end
            n_cmp++;
            if (n >= 200) begin
                n_err++;
                $display("FAIL %s_timeout: out_valid=%0b required 1 at result %0d", tag, out_valid, o);
                out_ready = 1'b0;
                return;
            end
            if (int'($signed(out_data)) !== expv[o]) begin
                n_err++;
                $display("FAIL %s_res%0d: got %0d required %0d", tag, o, $signed(out_data), expv[o]);
            end
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_end: out_valid=%0b busy=%0b required 0 0", tag, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b required 0", busy); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    endtask

    task automatic test_ignored_opcode();
        send(16'h1234, 0);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL ignored_opcode_busy: got %0b required 0", busy); end
    endtask

    task automatic test_all_plus();
        for (int k = 0; k < 16; k++) wl[k] = 16'h5555;
        for (int m = 0; m < 8; m++) xv[m] = 16'h0102;
        load_weights(0);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL load_return_idle: busy=%0b required 0", busy); end
        do_mult(0);
        for (int o = 0; o < OUT_LEN; o++) expv[o] = 24;
        drain("all_plus", 1'b0);
    endtask

    task automatic test_all_minus();
        for (int k = 0; k < 16; k++) wl[k] = 16'hFFFF;
        for (int m = 0; m < 8; m++) xv[m] = 16'h7F7F;
        load_weights(0);
        do_mult(0);
`ifdef TERNARY_MVM_SAT_EN
        for (int o = 0; o < OUT_LEN; o++) expv[o] = -128;
`else
        for (int o = 0; o < OUT_LEN; o++) expv[o] = -2032;
`endif
        drain("all_minus", 1'b0);
    endtask

    task automatic test_stall();
        for (int k = 0; k < 16; k++) wl[k] = (k < 2) ? 16'h5555 : 16'h0000;
        for (int m = 0; m < 8; m++) xv[m] = 16'h0102;
        load_weights(1);
        do_mult(0);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || int'($signed(out_data)) !== 24) begin
                n_err++;
                $display("FAIL stall_hold%0d: valid=%0b busy=%0b in_ready=%0b data=%0d required 1 1 0 24",
                         c, out_valid, busy, in_ready, $signed(out_data));
            end
        end
        expv[0] = 24;
        for (int o = 1; o < OUT_LEN; o++) expv[o] = 0;
        drain("stall", 1'b0);
    endtask

    task automatic test_clear();
        for (int k = 0; k < 16; k++) wl[k] = 16'h5555;
        for (int m = 0; m < 8; m++) xv[m] = 16'h0102;
        load_weights(0);
        send(16'hC000, 0);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL clear_busy: got %0b required 0", busy); end
        do_mult(0);
        for (int o = 0; o < OUT_LEN; o++) expv[o] = 0;
        drain("clear", 1'b0);
    endtask

    task automatic test_reset_mid_mult();
        for (int k = 0; k < 16; k++) wl[k] = 16'h5555;
        for (int m = 0; m < 8; m++) xv[m] = 16'h0101;
        load_weights(0);
        send(16'hF000, 0);
        for (int m = 0; m < 4; m++) send(xv[m], 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_state: valid=%0b busy=%0b in_ready=%0b required 0 0 1", out_valid, busy, in_ready);
        end
        do_mult(0);
        for (int o = 0; o < OUT_LEN; o++) expv[o] = 0;
        drain("midreset", 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 16; k++) wl[k] = 16'($urandom);
            for (int m = 0; m < 8; m++) xv[m] = 16'($urandom);
            load_weights(2);
            do_mult(2);
            for (int o = 0; o < OUT_LEN; o++) expv[o] = model(o);
            drain("random", 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_ignored_opcode();
        test_all_plus();
        test_all_minus();
        test_stall();
        test_clear();
        test_reset_mid_mult();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ternary_mvm_engine.md
TERNARY_MVM_ENGINE -- requirements
Module: ternary_mvm_engine

Interface
REQ-001 SHALL have parameter IN_LEN, default 16: input vector length; even, IN_LEN*OUT_LEN a multiple of 8.
REQ-002 SHALL have parameter OUT_LEN, default 8: output vector length (matrix rows).
REQ-003 SHALL have parameter IN_W, default 8: signed input element width.
REQ-004 SHALL have parameter OUT_W, default IN_W+$clog2(IN_LEN)+1: signed result width.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  1  in_data word offered.
REQ-008 in_ready  output  1  engine accepts in_data this cycle.
REQ-009 in_data  input  16  command, weight or vector word.
REQ-010 out_valid  output  1  out_data holds a result.
REQ-011 out_ready  input  1  consumer accepts out_data.
REQ-012 out_data  output  OUT_W  signed result element.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL treat a word as accepted only when in_valid and in_ready are both high; a result as consumed only when out_valid and out_ready are both high.
REQ-015 SHALL implement states IDLE, LOAD, MULT, OUT; in_ready = 1 in IDLE, LOAD and MULT, 0 in OUT.
REQ-016 IDLE: an accepted word with in_data[15:12]=0xA -> LOAD; 0xF -> MULT and clear all OUT_LEN accumulators; 0xC -> clear all weights to 0 in that cycle and stay IDLE; any other opcode is consumed and ignored; in_data[11:0] are ignored.
REQ-017 Weight w[o][i] (o<OUT_LEN, i<IN_LEN) SHALL be a 2-bit code: 01=+1, 11=-1, 00 and 10=0.
REQ-018 LOAD SHALL accept exactly IN_LEN*OUT_LEN/8 words; word k, bits [2j+1:2j], sets flat weight index 8k+j, where flat index = o*IN_LEN+i.
REQ-019 After the last LOAD word is accepted, state SHALL return to IDLE on the next cycle; idle-cycle gaps (in_valid low) SHALL pause without loss.
REQ-020 MULT SHALL accept exactly IN_LEN/2 words; word m carries x[2m] in bits [15:8] and x[2m+1] in bits [7:0] (for IN_W=8), both signed.
REQ-021 Each accepted MULT word SHALL update all OUT_LEN accumulators in the same cycle: acc[o] += w[o][2m]*x[2m] + w[o][2m+1]*x[2m+1], computed as add, subtract or skip.
REQ-022 Accumulators SHALL be OUT_W bits and cannot overflow for any legal input at the default OUT_W.
REQ-023 The cycle after the last MULT word is accepted, state SHALL be OUT with out_valid=1 and out_data=acc[0].
REQ-024 OUT: each consumption advances to acc[o+1]; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 On consumption of acc[OUT_LEN-1], out_valid SHALL drop and state SHALL be IDLE on the next cycle.
REQ-026 Weights SHALL persist across MULT runs until reloaded, cleared (0xC) or reset.

Reset
REQ-027 With rst_n low at a clock edge: state=IDLE, out_valid=0, busy=0, all accumulators 0, all weights 0, all counters 0; in_ready=1 from the first cycle after reset.
REQ-028 Reset asserted mid-LOAD, mid-MULT or mid-OUT SHALL abort the operation with no result emitted.

Configuration
REQ-029 Macro TERNARY_MVM_SAT_EN: when defined, out_data SHALL be acc[o] saturated to the signed IN_W range, sign-extended to OUT_W; when undefined, out_data SHALL be the full-width acc[o].

Verification
REQ-030 Reset, then 0xA000 + 16 words 0x5555 (all +1), 0xF000, 8 words 0x0102 -> 8 results, each 24 (8*1 + 8*2).
REQ-031 Load all-11 weights (0xFFFF x16), MULT 8 words 0x7F7F -> each result -2032; with TERNARY_MVM_SAT_EN -> -128.
REQ-032 Load row 0 = +1, others 0; MULT with out_ready held low 5 cycles -> out_data=acc[0] stable, busy=1, in_ready=0 throughout.
REQ-033 Load, 0xC000, MULT any nonzero data -> all 8 results 0.
REQ-034 Assert rst_n low after 4 MULT words, then full MULT with 0x0101 -> weights 0, all results 0, no stale out_valid.
REQ-035 Random in_valid/out_ready gaps with random weights and data -> results match reference model bit-exactly.
